// File: rtl/spi_sck_pkg.sv
// Shared types and helpers for the SPI serial-clock engine.
// SPI_SCK_GUARD_EN enables the LEAD/TRAIL guard states handled in spi_sck_engine.
package spi_sck_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEAD  = 2'd1,
    RUN   = 2'd2,
    TRAIL = 2'd3
  } state_t;

  // Half-period counter width: the largest half-period, 2^sppr_w << (2^spr_w - 1),
  // must be representable.
  function automatic int cnt_width(input int sppr_w, input int spr_w);
    return sppr_w + (1 << spr_w);
  endfunction

endpackage

// File: rtl/spi_sck_prescaler.sv
// Half-period timer: counts 0..H-1 with H = (sppr+1) << spr, one-cycle tick at wrap.
// The counter is held at zero whenever run_en is low, so every phase starts fresh.
module spi_sck_prescaler
  import spi_sck_pkg::*;
#(
  parameter int SPPR_W = 3,
  parameter int SPR_W  = 3
) (
  input  logic              clk_in,
  input  logic              rstn_in,
  input  logic [SPPR_W-1:0] sppr,
  input  logic [SPR_W-1:0]  spr,
  input  logic              run_en,
  output logic              tick
);

  localparam int CNT_W = cnt_width(SPPR_W, SPR_W);

  logic [CNT_W-1:0] half;
  logic [CNT_W-1:0] cnt_q;

  assign half = (CNT_W'(sppr) + CNT_W'(1)) << spr;
  assign tick = run_en && (cnt_q == (half - CNT_W'(1)));

  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      cnt_q <= '0;
    end else if (!run_en || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/spi_sck_engine.sv
// SPI SCK engine: frames one burst of 2*len SCK edges with CPOL/CPHA strobes.
// Optional macro SPI_SCK_GUARD_EN adds one half-period of guard before and after the burst.
//
// state | meaning
// IDLE  | sck follows cpol_in, waiting for an accepted start
// LEAD  | guard half-period at idle level before the first edge (guard build only)
// RUN   | counting half-periods, toggling sck and firing strobes
// TRAIL | guard half-period after the last edge, done at its end (guard build only)
module spi_sck_engine
  import spi_sck_pkg::*;
#(
  parameter int SPPR_W = 3,
  parameter int SPR_W  = 3,
  parameter int LEN_W  = 5
) (
  input  logic              clk_in,
  input  logic              rstn_in,
  input  logic              enable_in,
  input  logic              start_in,
  input  logic [LEN_W-1:0]  len_in,
  input  logic [SPPR_W-1:0] sppr_in,
  input  logic [SPR_W-1:0]  spr_in,
  input  logic              cpol_in,
  input  logic              cpha_in,
  output logic              sck_out,
  output logic              sample_out,
  output logic              shift_out,
  output logic              busy_out,
  output logic              done_out
);

`ifdef SPI_SCK_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  state_t state_q, state_d;

  logic [LEN_W-1:0]  len_q;
  logic [SPPR_W-1:0] sppr_q;
  logic [SPR_W-1:0]  spr_q;
  logic              cpha_q;
  logic              cpol_q;

  logic [LEN_W:0] edge_q, edge_d, next_edge, last_edge;
  logic sck_q, sck_d;
  logic sample_q, sample_d;
  logic shift_q, shift_d;
  logic done_q, done_d;
  logic accept, final_edge_seen, run_en, tick, leading;

  assign last_edge       = {len_q, 1'b0};
  assign next_edge       = edge_q + (LEN_W+1)'(1);
  assign final_edge_seen = (edge_q == last_edge);
  assign leading         = next_edge[0];
  assign accept          = (state_q == IDLE) && enable_in && start_in && (len_in != '0);

  // The final-edge cycle of RUN is spent with the timer parked so TRAIL starts from zero.
  assign run_en = enable_in &&
                  ((state_q == LEAD) || (state_q == TRAIL) ||
                   ((state_q == RUN) && !final_edge_seen));

  spi_sck_prescaler #(
    .SPPR_W (SPPR_W),
    .SPR_W  (SPR_W)
  ) u_prescaler (
    .clk_in  (clk_in),
    .rstn_in (rstn_in),
    .sppr    (sppr_q),
    .spr     (spr_q),
    .run_en  (run_en),
    .tick    (tick)
  );

  always_comb begin
    state_d  = state_q;
    edge_d   = edge_q;
    sck_d    = sck_q;
    sample_d = 1'b0;
    shift_d  = 1'b0;
    done_d   = 1'b0;

    if (!enable_in) begin
      state_d = IDLE;
      edge_d  = '0;
      sck_d   = cpol_in;
    end else begin
      case (state_q)
        IDLE: begin
          sck_d  = cpol_in;
          edge_d = '0;
          if (accept) begin
            if (GUARD) state_d = LEAD;
            else       state_d = RUN;
          end
        end
        LEAD: begin
          sck_d = cpol_q;
          if (tick) state_d = RUN;
        end
        RUN: begin
          if (final_edge_seen) begin
            if (GUARD) state_d = TRAIL;
            else       state_d = IDLE;
          end else if (tick) begin
            edge_d = next_edge;
            sck_d  = (next_edge == last_edge) ? cpol_q : ~sck_q;
            if (cpha_q) begin
              shift_d  = leading;
              sample_d = !leading;
            end else begin
              sample_d = leading;
              shift_d  = !leading && (next_edge != last_edge);
            end
            done_d = !GUARD && (next_edge == last_edge);
          end
        end
        TRAIL: begin
          if (tick) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      edge_q   <= '0;
      sck_q    <= 1'b0;
      sample_q <= 1'b0;
      shift_q  <= 1'b0;
      done_q   <= 1'b0;
      len_q    <= '0;
      sppr_q   <= '0;
      spr_q    <= '0;
      cpha_q   <= 1'b0;
      cpol_q   <= 1'b0;
    end else begin
      edge_q   <= edge_d;
      sck_q    <= sck_d;
      sample_q <= sample_d;
      shift_q  <= shift_d;
      done_q   <= done_d;
      if (accept) begin
        len_q  <= len_in;
        sppr_q <= sppr_in;
        spr_q  <= spr_in;
        cpha_q <= cpha_in;
        cpol_q <= cpol_in;
      end
    end
  end

  assign sck_out    = sck_q;
  assign sample_out = sample_q;
  assign shift_out  = shift_q;
  assign busy_out   = (state_q != IDLE);
  assign done_out   = GUARD ? ((state_q == TRAIL) && tick) : done_q;

endmodule
